// File: rtl/hurricane_ctrl.sv
// Hurricane (mode 3) run-time controller.
// Times a fixed-length hurricane run, reports the seconds left, and tells the
// mode machine when to leave mode 3 and where to go (mode 2 or standby).
// Optional feature macro: HURRICANE_ONCE_EN -- when defined, hurricane may be used
// only once per power-on (DONE -> USED, locked until machine_state drops).
module hurricane_ctrl #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned RUN_SEC = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       machine_state,
  input  logic [2:0] mode_state,
  input  logic       menu_btn,
  output logic       hurricane_mode_enabled,
  output logic       return_state,
  output logic [6:0] remain_sec,
  output logic       active
);

  localparam int unsigned PW          = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PrescMax  = PW'(CLK_HZ - 1);
  localparam logic [6:0] RunSec       = 7'(RUN_SEC);
  localparam logic [2:0] ModeHurricane = 3'b011;

  typedef enum logic [1:0] {StIdle, StRun, StDone, StUsed} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [6:0]    remain_q, remain_d;
  logic          ret_q, ret_d;
  logic          menu_q;

  logic in_hurricane;
  logic menu_edge;
  logic tick;

  assign in_hurricane = (mode_state == ModeHurricane);
  assign menu_edge    = menu_btn & ~menu_q;
  assign tick         = (presc_q == PrescMax);

  // State and datapath registers; menu history tracks the button every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      presc_q  <= '0;
      remain_q <= RunSec;
      ret_q    <= 1'b0;
      menu_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      remain_q <= remain_d;
      ret_q    <= ret_d;
      menu_q   <= menu_btn;
    end
  end

  // Next-state and datapath update; power-off overrides every state.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    remain_d = remain_q;
    ret_d    = ret_q;
    if (!machine_state) begin
      state_d  = StIdle;
      presc_d  = '0;
      remain_d = RunSec;
      ret_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_hurricane) begin
            state_d  = StRun;
            presc_d  = '0;
            remain_d = RunSec;
            ret_d    = 1'b0;
          end
        end
        StRun: begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (tick && remain_q != 7'd0) remain_d = remain_q - 7'd1;
          // Menu edge beats expiry so a late press still returns to mode 2.
          if (menu_edge) begin
            state_d = StDone;
            ret_d   = 1'b1;
          end else if (tick && remain_q == 7'd1) begin
            state_d = StDone;
            ret_d   = 1'b0;
          end else if (!in_hurricane) begin
            state_d = StDone;
          end
        end
        StDone: begin
          if (!in_hurricane) begin
`ifdef HURRICANE_ONCE_EN
            state_d  = StUsed;
            remain_d = 7'd0;
`else
            state_d  = StIdle;
            presc_d  = '0;
            remain_d = RunSec;
            ret_d    = 1'b0;
`endif
          end
        end
        StUsed: begin
          remain_d = 7'd0;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs decode registered state, so they lag the trigger by one cycle.
  always_comb begin
    hurricane_mode_enabled = 1'b0;
    active                 = 1'b0;
    return_state           = ret_q;
    remain_sec             = remain_q;
    unique case (state_q)
      StIdle: hurricane_mode_enabled = 1'b1;
      StRun: begin
        hurricane_mode_enabled = 1'b1;
        active                 = 1'b1;
      end
      StDone: hurricane_mode_enabled = 1'b0;
      StUsed: hurricane_mode_enabled = 1'b0;
      default: hurricane_mode_enabled = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_hurricane_ctrl.sv
// Directed bench for hurricane_ctrl with CLK_HZ=10, RUN_SEC=3.
module tb_hurricane_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       machine_state;
  logic [2:0] mode_state;
  logic       menu_btn;
  logic       hurricane_mode_enabled;
  logic       return_state;
  logic [6:0] remain_sec;
  logic       active;

  int n_pass = 0;
  int n_total = 0;

  hurricane_ctrl #(
    .CLK_HZ (10),
    .RUN_SEC(3)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .machine_state         (machine_state),
    .mode_state            (mode_state),
    .menu_btn              (menu_btn),
    .hurricane_mode_enabled(hurricane_mode_enabled),
    .return_state          (return_state),
    .remain_sec            (remain_sec),
    .active                (active)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_en"}, 32'(hurricane_mode_enabled), 1);
    check({tag, "_ret"}, 32'(return_state), 0);
    check({tag, "_rem"}, 32'(remain_sec), 3);
    check({tag, "_act"}, 32'(active), 0);
  endtask

  initial begin
    rst = 1'b1; machine_state = 1'b0; mode_state = 3'd0; menu_btn = 1'b0;
    step(2);
    rst = 1'b0;
    check_idle("reset");

    // Full run to expiry.
    machine_state = 1'b1;
    step(1);
    mode_state = 3'd3;
    step(1);
    check("run_act", 32'(active), 1);
    check("run_rem3", 32'(remain_sec), 3);
    step(9);
    check("run_rem3_late", 32'(remain_sec), 3);
    step(1);
    check("run_rem2", 32'(remain_sec), 2);
    step(10);
    check("run_rem1", 32'(remain_sec), 1);
    step(10);
    check("exp_rem0", 32'(remain_sec), 0);
    check("exp_en", 32'(hurricane_mode_enabled), 0);
    check("exp_ret", 32'(return_state), 0);
    check("exp_act", 32'(active), 0);
    step(1);
    check("done_hold_en", 32'(hurricane_mode_enabled), 0);

    // Leave mode 3, then request it again.
    mode_state = 3'd0;
    step(1);
    mode_state = 3'd3;
    step(1);
`ifdef HURRICANE_ONCE_EN
    check("once_locked_en", 32'(hurricane_mode_enabled), 0);
    check("once_locked_rem", 32'(remain_sec), 0);
`else
    check("rearm_en", 32'(hurricane_mode_enabled), 1);
    check("rearm_act", 32'(active), 1);
`endif
    machine_state = 1'b0; mode_state = 3'd0;
    step(1);
    check_idle("poweroff1");
    machine_state = 1'b1;

    // Menu abort at remain_sec=2.
    mode_state = 3'd3;
    step(11);
    check("menu_pre_rem", 32'(remain_sec), 2);
    menu_btn = 1'b1;
    step(1);
    menu_btn = 1'b0;
    check("menu_en", 32'(hurricane_mode_enabled), 0);
    check("menu_ret", 32'(return_state), 1);
    check("menu_act", 32'(active), 0);
    mode_state = 3'd0;
    step(1);
`ifdef HURRICANE_ONCE_EN
    check("menu_used_ret", 32'(return_state), 1);
`else
    check("menu_idle_ret", 32'(return_state), 0);
`endif
    machine_state = 1'b0;
    step(1);
    check_idle("poweroff2");
    machine_state = 1'b1;

    // Menu edge on the exact expiry cycle.
    mode_state = 3'd3;
    step(1);
    step(29);
    check("tie_pre_rem", 32'(remain_sec), 1);
    menu_btn = 1'b1;
    step(1);
    menu_btn = 1'b0;
    check("tie_ret", 32'(return_state), 1);
    check("tie_rem", 32'(remain_sec), 0);
    check("tie_en", 32'(hurricane_mode_enabled), 0);
    machine_state = 1'b0; mode_state = 3'd0;
    step(1);
    check_idle("poweroff3");

    // Reset mid-run at remain_sec=1.
    machine_state = 1'b1; mode_state = 3'd3;
    step(1);
    step(20);
    check("rstrun_rem", 32'(remain_sec), 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_idle("rstrun");

    // External exit from mode 3 during RUN.
    step(1);
    check("ext_act", 32'(active), 1);
    mode_state = 3'd0;
    step(1);
    check("ext_en", 32'(hurricane_mode_enabled), 0);
    check("ext_ret", 32'(return_state), 0);
    machine_state = 1'b0;
    step(1);
    check_idle("poweroff4");

    // Menu held high before RUN must not cause an exit.
    machine_state = 1'b1; menu_btn = 1'b1;
    step(2);
    mode_state = 3'd3;
    step(1);
    step(5);
    check("held_act", 32'(active), 1);
    check("held_en", 32'(hurricane_mode_enabled), 1);
    step(25);
    check("held_exp_en", 32'(hurricane_mode_enabled), 0);
    check("held_exp_ret", 32'(return_state), 0);

    // Power-off during DONE.
    machine_state = 1'b0;
    step(1);
    check_idle("done_off");
    menu_btn = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
